// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: one FSM services instruction fetches and data loads/stores
// over an 8-bit RAM port. Define MEM_CTRL_DATA_PRIORITY_EN to let data requests win ties.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        instruction_flag,
  output logic [31:0] instruction_read_address,
  output logic [31:0] instruction,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_wr
);

  typedef enum logic [2:0] {
    IDLE,
    IREAD,
    DREAD,
    DWRITE,
    DONE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [2:0]  cnt;
  logic [31:0] base;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic [31:0] buffer;
  logic        is_inst;

  logic        take_inst;
  logic        take_data;
  logic [2:0]  n;
  logic [4:0]  shamt;
  logic [31:0] assembled;
  logic [7:0]  wbyte;

  // Arbitration between simultaneous requests
  always_comb begin
`ifdef MEM_CTRL_DATA_PRIORITY_EN
    take_data = data_req;
    take_inst = inst_req && !data_req;
`else
    take_inst = inst_req;
    take_data = data_req && !inst_req;
`endif
  end

  // Transfer length, and merging of the byte arriving this cycle (byte cnt-1)
  always_comb begin
    n = 3'd4;
    if (state == DREAD || state == DWRITE) begin
      case (size)
        2'b00:   n = 3'd1;
        2'b01:   n = 3'd2;
        default: n = 3'd4;
      endcase
    end
    shamt     = {cnt[1:0] - 2'd1, 3'b000};
    assembled = buffer | ({24'd0, mem_din} << shamt);
    wbyte     = wdata[{cnt[1:0], 3'b000} +: 8];
  end

  always_comb begin
    next_state       = state;
    mem_a            = 32'd0;
    mem_dout         = 8'd0;
    mem_wr           = 1'b0;
    instruction_flag = 1'b0;
    data_done        = 1'b0;
    case (state)
      IDLE: begin
        if (take_inst) begin
          next_state = IREAD;
        end else if (take_data) begin
          next_state = data_we ? DWRITE : DREAD;
        end
      end
      IREAD, DREAD: begin
        if (cnt < n) begin
          mem_a = base + {29'd0, cnt};
        end
        if (cnt == n) begin
          next_state = DONE;
        end
      end
      DWRITE: begin
        // A write never commits while reset is being applied
        mem_a    = base + {29'd0, cnt};
        mem_dout = wbyte;
        mem_wr   = !rst;
        if (cnt == n - 3'd1) begin
          next_state = DONE;
        end
      end
      DONE: begin
        instruction_flag = is_inst;
        data_done        = !is_inst;
        next_state       = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= IDLE;
      cnt                      <= 3'd0;
      base                     <= 32'd0;
      size                     <= 2'd0;
      wdata                    <= 32'd0;
      buffer                   <= 32'd0;
      is_inst                  <= 1'b0;
      instruction              <= 32'd0;
      instruction_read_address <= 32'd0;
      data_rdata               <= 32'd0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (take_inst || take_data) begin
            base    <= take_inst ? inst_addr : data_addr;
            size    <= data_size;
            wdata   <= data_wdata;
            buffer  <= 32'd0;
            is_inst <= take_inst;
          end
        end
        IREAD, DREAD: begin
          // Results are published only when the whole word is in hand
          if (cnt == n) begin
            cnt <= 3'd0;
            if (is_inst) begin
              instruction              <= assembled;
              instruction_read_address <= base;
            end else begin
              data_rdata <= assembled;
            end
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt != 3'd0) begin
              buffer <= assembled;
            end
          end
        end
        DWRITE: begin
          cnt <= (cnt == n - 3'd1) ? 3'd0 : cnt + 3'd1;
        end
        default: cnt <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide RAM model (registered read, one-cycle latency).
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        instruction_flag;
  logic [31:0] instruction_read_address;
  logic [31:0] instruction;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_wr;

  logic [7:0]  ram [0:4095];
  int          total;
  int          bad;

  mem_ctrl dut (
    .clk                      (clk),
    .rst                      (rst),
    .inst_req                 (inst_req),
    .inst_addr                (inst_addr),
    .instruction_flag         (instruction_flag),
    .instruction_read_address (instruction_read_address),
    .instruction              (instruction),
    .data_req                 (data_req),
    .data_we                  (data_we),
    .data_addr                (data_addr),
    .data_size                (data_size),
    .data_wdata               (data_wdata),
    .data_rdata               (data_rdata),
    .data_done                (data_done),
    .mem_a                    (mem_a),
    .mem_dout                 (mem_dout),
    .mem_din                  (mem_din),
    .mem_wr                   (mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write on the edge, read data appears the cycle after the address
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic tick(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                               input logic we, input logic [31:0] daddr, input logic [1:0] dsize,
                               input logic [31:0] wdat);
    inst_req   = ireq;
    inst_addr  = iaddr;
    data_req   = dreq;
    data_we    = we;
    data_addr  = daddr;
    data_size  = dsize;
    data_wdata = wdat;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h300] = 8'h80; ram[12'h301] = 8'hFF;
    ram[12'hFFF] = 8'h34; ram[12'h000] = 8'h12;
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
    tick(2);

    checkOutput("reset_flag", {31'd0, instruction_flag}, 32'd0);
    checkOutput("reset_done", {31'd0, data_done}, 32'd0);
    checkOutput("reset_mem_a", mem_a, 32'd0);
    checkOutput("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("reset_instruction", instruction, 32'd0);
    checkOutput("reset_rdata", data_rdata, 32'd0);

    // Instruction fetch from 0x100, held high through the flag
    rst = 1'b0;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0);
    tick(1);
    checkOutput("fetch_c1_mem_a", mem_a, 32'h100);
    checkOutput("fetch_c1_mem_wr", {31'd0, mem_wr}, 32'd0);
    inst_addr = 32'h500;
    tick(1);
    checkOutput("fetch_c2_mem_a", mem_a, 32'h101);
    tick(3);
    checkOutput("fetch_c5_flag", {31'd0, instruction_flag}, 32'd0);
    checkOutput("fetch_c5_mem_a_idle_slot", mem_a, 32'd0);
    tick(1);
    checkOutput("fetch_c6_flag", {31'd0, instruction_flag}, 32'd1);
    checkOutput("fetch_c6_instruction", instruction, 32'h00000513);
    checkOutput("fetch_c6_address", instruction_read_address, 32'h100);
    tick(1);
    checkOutput("fetch_c7_flag_low", {31'd0, instruction_flag}, 32'd0);
    checkOutput("fetch_c7_no_restart", mem_a, 32'd0);
    tick(1);
    checkOutput("fetch2_c1_mem_a", mem_a, 32'h500);
    inst_req = 1'b0;
    tick(4);
    checkOutput("fetch2_hold_instruction", instruction, 32'h00000513);
    tick(1);
    checkOutput("fetch2_flag", {31'd0, instruction_flag}, 32'd1);
    checkOutput("fetch2_instruction", instruction, 32'h00000000);
    checkOutput("fetch2_address", instruction_read_address, 32'h500);
    tick(1);

    // Word store of 0xDEADBEEF to 0x200
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h200, 2'b10, 32'hDEADBEEF);
    tick(1);
    checkOutput("store_c1_mem_a", mem_a, 32'h200);
    checkOutput("store_c1_dout", {24'd0, mem_dout}, 32'hEF);
    checkOutput("store_c1_wr", {31'd0, mem_wr}, 32'd1);
    data_wdata = 32'h0;
    data_addr  = 32'h700;
    tick(1);
    checkOutput("store_c2_dout", {24'd0, mem_dout}, 32'hBE);
    tick(1);
    checkOutput("store_c3_mem_a", mem_a, 32'h202);
    tick(1);
    checkOutput("store_c4_dout", {24'd0, mem_dout}, 32'hDE);
    checkOutput("store_c4_done", {31'd0, data_done}, 32'd0);
    tick(1);
    checkOutput("store_c5_done", {31'd0, data_done}, 32'd1);
    checkOutput("store_c5_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("store_c5_dout", {24'd0, mem_dout}, 32'd0);
    data_req = 1'b0;
    tick(1);
    checkOutput("store_ram", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'hDEADBEEF);

    // Byte load from 0x300
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h300, 2'b00, 32'd0);
    tick(1);
    checkOutput("lb_c1_mem_a", mem_a, 32'h300);
    tick(1);
    checkOutput("lb_c2_done", {31'd0, data_done}, 32'd0);
    tick(1);
    checkOutput("lb_c3_done", {31'd0, data_done}, 32'd1);
    checkOutput("lb_c3_rdata", data_rdata, 32'h00000080);
    data_req = 1'b0;
    tick(1);

    // Half load from 0x300
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h300, 2'b01, 32'd0);
    tick(3);
    checkOutput("lh_c3_hold_rdata", data_rdata, 32'h00000080);
    checkOutput("lh_c3_done", {31'd0, data_done}, 32'd0);
    tick(1);
    checkOutput("lh_c4_done", {31'd0, data_done}, 32'd1);
    checkOutput("lh_c4_rdata", data_rdata, 32'h0000FF80);
    data_req = 1'b0;
    tick(1);

    // Half load straddling the top of the address space
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 2'b01, 32'd0);
    tick(1);
    checkOutput("wrap_c1_mem_a", mem_a, 32'hFFFFFFFF);
    tick(1);
    checkOutput("wrap_c2_mem_a", mem_a, 32'h00000000);
    tick(2);
    checkOutput("wrap_c4_rdata", data_rdata, 32'h00001234);
    data_req = 1'b0;
    tick(1);

    // Simultaneous instruction fetch and byte load
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 2'b00, 32'd0);
    tick(1);
`ifdef MEM_CTRL_DATA_PRIORITY_EN
    checkOutput("tie_c1_mem_a", mem_a, 32'h300);
    tick(2);
    checkOutput("tie_c3_done", {31'd0, data_done}, 32'd1);
    data_req = 1'b0;
    tick(2);
    checkOutput("tie_c5_mem_a", mem_a, 32'h100);
    tick(5);
    checkOutput("tie_c10_flag", {31'd0, instruction_flag}, 32'd1);
    inst_req = 1'b0;
`else
    checkOutput("tie_c1_mem_a", mem_a, 32'h100);
    tick(5);
    checkOutput("tie_c6_flag", {31'd0, instruction_flag}, 32'd1);
    checkOutput("tie_c6_done", {31'd0, data_done}, 32'd0);
    inst_req = 1'b0;
    tick(2);
    checkOutput("tie_c8_mem_a", mem_a, 32'h300);
    tick(2);
    checkOutput("tie_c10_done", {31'd0, data_done}, 32'd1);
    data_req = 1'b0;
`endif
    tick(1);

    // Reset during a word store aborts it after two bytes
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h600, 2'b10, 32'h11223344);
    tick(3);
    rst = 1'b1;
    tick(1);
    checkOutput("abort_c4_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("abort_c4_mem_a", mem_a, 32'd0);
    checkOutput("abort_c4_done", {31'd0, data_done}, 32'd0);
    rst = 1'b0;
    data_req = 1'b0;
    tick(1);
    checkOutput("abort_c5_done", {31'd0, data_done}, 32'd0);
    checkOutput("abort_ram", {ram[12'h603], ram[12'h602], ram[12'h601], ram[12'h600]}, 32'h00003344);
    checkOutput("abort_rdata_cleared", data_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
